// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, line levels
// and the frame-length helper used by the RX side and by benches.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Total clocks for one frame: start + data + optional parity + stop bits.
    function automatic int frame_clks(input int data_bits, input int stop_bits,
                                      input int parity, input int clks_per_bit);
        return (1 + data_bits + parity + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word-source to transmitter handshake plus the transmitter status/line outputs.
// The source side uses the master modport, the transmitter the slave modport.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_TX_Data_Valid;
    logic [DATA_BITS-1:0] i_TX_Byte;
    logic                 o_TX_Ready;
    logic                 o_TX_Active;
    logic                 o_TX_Serial;
    logic                 o_TX_Done;

    modport master (
        output i_TX_Data_Valid,
        output i_TX_Byte,
        input  o_TX_Ready,
        input  o_TX_Active,
        input  o_TX_Serial,
        input  o_TX_Done
    );

    modport slave (
        input  i_TX_Data_Valid,
        input  i_TX_Byte,
        output o_TX_Ready,
        output o_TX_Active,
        output o_TX_Serial,
        output o_TX_Done
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count. Shared between the transmitter and the receiver.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);
    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    assign bit_end = enable && !clear && (cnt_r == TERM);

    // Clock counter: cleared while idle, wraps to zero at the end of each bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            if (cnt_r == TERM) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB-first,
// optional parity bit, STOP_BITS stop bits. Define UART_TX_PARITY_EN to add
// the parity bit (even when PARITY_ODD=0, odd when PARITY_ODD=1).
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    uart_tx_cfg_if.slave  tx
);
    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    // Reject configurations outside the supported range at elaboration.
    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
            STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_tx_cfg: parameter out of legal range");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    // Parity over the latched word, inverted for odd parity.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction
`endif

    tx_state_t            state_r;
    tx_state_t            next_state_s;
    logic [DATA_BITS-1:0] data_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [IDX_W-1:0]     next_idx_s;
    logic [IDX_W-1:0]     idx_plus_s;
    logic                 serial_r;
    logic                 next_serial_s;
    logic                 active_r;
    logic                 next_active_s;
    logic                 done_r;
    logic                 next_done_s;
    logic                 load_s;
    logic                 bit_end_s;
    logic                 cnt_clear_s;

    assign cnt_clear_s = (state_r == IDLE);
    assign idx_plus_s  = bit_idx_r + 1'b1;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .clear   (cnt_clear_s),
        .enable  (!cnt_clear_s),
        .bit_end (bit_end_s)
    );

    // Next-state and next-output decode; line value is registered on state entry.
    always_comb begin
        next_state_s  = state_r;
        next_idx_s    = bit_idx_r;
        next_serial_s = serial_r;
        next_active_s = active_r;
        next_done_s   = 1'b0;
        load_s        = 1'b0;
        case (state_r)
            IDLE: begin
                next_serial_s = IDLE_LEVEL;
                next_active_s = 1'b0;
                if (tx.i_TX_Data_Valid) begin
                    next_state_s  = START;
                    next_serial_s = START_LEVEL;
                    next_active_s = 1'b1;
                    next_idx_s    = '0;
                    load_s        = 1'b1;
                end else begin
                    next_state_s  = IDLE;
                end
            end
            START: begin
                next_active_s = 1'b1;
                if (bit_end_s) begin
                    next_state_s  = DATA;
                    next_serial_s = data_r[0];
                    next_idx_s    = '0;
                end else begin
                    next_serial_s = START_LEVEL;
                end
            end
            DATA: begin
                next_active_s = 1'b1;
                if (bit_end_s) begin
                    if (bit_idx_r == LAST_DATA) begin
                        next_idx_s    = '0;
`ifdef UART_TX_PARITY_EN
                        next_state_s  = PARITY;
                        next_serial_s = parity_bit(data_r);
`else
                        next_state_s  = STOP;
                        next_serial_s = IDLE_LEVEL;
`endif
                    end else begin
                        next_idx_s    = idx_plus_s;
                        next_serial_s = data_r[idx_plus_s];
                    end
                end else begin
                    next_serial_s = data_r[bit_idx_r];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                next_active_s = 1'b1;
                if (bit_end_s) begin
                    next_state_s  = STOP;
                    next_serial_s = IDLE_LEVEL;
                    next_idx_s    = '0;
                end else begin
                    next_serial_s = parity_bit(data_r);
                end
            end
`endif
            STOP: begin
                next_serial_s = IDLE_LEVEL;
                next_active_s = 1'b1;
                if (bit_end_s) begin
                    if (bit_idx_r == LAST_STOP) begin
                        next_state_s  = IDLE;
                        next_active_s = 1'b0;
                        next_done_s   = 1'b1;
                        next_idx_s    = '0;
                    end else begin
                        next_idx_s    = idx_plus_s;
                    end
                end else begin
                    next_idx_s    = bit_idx_r;
                end
            end
            default: begin
                next_state_s  = IDLE;
                next_serial_s = IDLE_LEVEL;
                next_active_s = 1'b0;
                next_idx_s    = '0;
            end
        endcase
    end

    // State, word latch, bit index and registered line/status outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r   <= IDLE;
            data_r    <= '0;
            bit_idx_r <= '0;
            serial_r  <= IDLE_LEVEL;
            active_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            bit_idx_r <= next_idx_s;
            serial_r  <= next_serial_s;
            active_r  <= next_active_s;
            done_r    <= next_done_s;
            if (load_s) begin
                data_r <= tx.i_TX_Byte;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign tx.o_TX_Ready  = (state_r == IDLE);
    assign tx.o_TX_Serial = serial_r;
    assign tx.o_TX_Active = active_r;
    assign tx.o_TX_Done   = done_r;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at CLKS_PER_BIT=4: 8-bit/1-stop (even),
// 5-bit/2-stop and 8-bit odd-parity instances behind one stimulus/observe mux.
module tb_uart_tx_cfg;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       valid;
    logic [8:0] byte_in;
    logic [1:0] sel;
    logic       obs_ready, obs_active, obs_serial, obs_done;
    int         vectors;
    int         miscompares;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_tx_cfg_if #(.DATA_BITS(5)) if_b ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();

    assign if_a.i_TX_Data_Valid = valid && (sel == 2'd0);
    assign if_a.i_TX_Byte       = byte_in[7:0];
    assign if_b.i_TX_Data_Valid = valid && (sel == 2'd1);
    assign if_b.i_TX_Byte       = byte_in[4:0];
    assign if_c.i_TX_Data_Valid = valid && (sel == 2'd2);
    assign if_c.i_TX_Byte       = byte_in[7:0];

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0))
        dut_a (.i_Clk(clk), .i_Rst(rst), .tx(if_a));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0))
        dut_b (.i_Clk(clk), .i_Rst(rst), .tx(if_b));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1))
        dut_c (.i_Clk(clk), .i_Rst(rst), .tx(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to the common observation signals.
    always_comb begin
        case (sel)
            2'd1:    {obs_ready, obs_active, obs_serial, obs_done} = {if_b.o_TX_Ready, if_b.o_TX_Active, if_b.o_TX_Serial, if_b.o_TX_Done};
            2'd2:    {obs_ready, obs_active, obs_serial, obs_done} = {if_c.o_TX_Ready, if_c.o_TX_Active, if_c.o_TX_Serial, if_c.o_TX_Done};
            default: {obs_ready, obs_active, obs_serial, obs_done} = {if_a.o_TX_Ready, if_a.o_TX_Active, if_a.o_TX_Serial, if_a.o_TX_Done};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line waveform (bit k-1 = line in clock k after acceptance), 4 clocks per bit.
    function automatic logic [63:0] exp_wave(input logic [8:0] d, input int nd, input int ns,
                                             input bit par, input bit odd, output int nclk);
        logic [15:0] bits;
        logic [63:0] w;
        logic        p;
        int          b;
        bits = '0;
        w    = '0;
        p    = odd;
        b    = 1;
        for (int i = 0; i < nd; i++) begin
            bits[b] = d[i];
            p       = p ^ d[i];
            b       = b + 1;
        end
        if (par) begin
            bits[b] = p;
            b       = b + 1;
        end
        for (int s = 0; s < ns; s++) begin
            bits[b] = 1'b1;
            b       = b + 1;
        end
        nclk = b * 4;
        for (int i = 0; i < nclk; i++) w[i] = bits[i / 4];
        return w;
    endfunction

    task automatic offer(input string tag, input logic [8:0] d);
        @(negedge clk);
        valid   = 1'b1;
        byte_in = d;
        check({tag, ".ready"}, {63'd0, obs_ready}, 64'd1);
    endtask

    // Follows one frame from the acceptance edge through Done; optionally keeps
    // valid high with the next word, or pokes a word mid-frame at clock poke_at.
    task automatic capture(input string tag, input logic [8:0] d, input int nd, input int ns,
                           input bit odd, input bit hold, input logic [8:0] nxt,
                           input int poke_at, output logic [63:0] ws);
        logic [63:0] ew, wa;
        int          n, acts;
        bit          dseen;
        ew    = exp_wave(d, nd, ns, PAR_ON, odd, n);
        ws    = '0;
        wa    = '0;
        acts  = 0;
        dseen = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ws[k-1] = obs_serial;
            wa[k-1] = obs_active;
            if (obs_active) acts++;
            if (obs_done) dseen = 1'b1;
            if (!hold && k == 1) valid = 1'b0;
            if (poke_at != 0 && k == poke_at) begin
                check({tag, ".busy_ready"}, {63'd0, obs_ready}, 64'd0);
                valid   = 1'b1;
                byte_in = nxt;
            end
            if (poke_at != 0 && k == poke_at + 1) valid = 1'b0;
        end
        check({tag, ".wave"}, ws, ew);
        check({tag, ".active"}, wa, (64'd1 << n) - 64'd1);
        check({tag, ".no_early_done"}, {63'd0, dseen}, 64'd0);
        check({tag, ".len"}, 64'(acts), 64'(frame_clks(nd, ns, int'(PAR_ON), 4)));
        @(negedge clk);
        check({tag, ".done"}, {60'd0, obs_done, obs_active, obs_ready, obs_serial}, 64'b1011);
        if (hold) begin
            byte_in = nxt;
        end else begin
            @(negedge clk);
            check({tag, ".done_1cyc"}, {62'd0, obs_done, obs_active}, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] w;
        logic [63:0] iw;
        bit          dseen;
        rst         = 1'b1;
        valid       = 1'b0;
        byte_in     = '0;
        sel         = 2'd0;
        vectors     = 0;
        miscompares = 0;

        // Reset values on every instance.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check($sformatf("reset%0d", s), {60'd0, obs_ready, obs_active, obs_serial, obs_done}, 64'b1010);
        end
        sel = 2'd0;
        @(negedge clk);
        rst = 1'b0;

        // 1: 0xA5, 8 data bits, 1 stop.
        offer("t1", 9'h0A5);
        capture("t1", 9'h0A5, 8, 1, 1'b0, 1'b0, 9'h000, 0, w);
`ifdef UART_TX_PARITY_EN
        check("t1.hand", w, 64'h0F0F0F00F0F0);
        check("t2.even_a5", {60'd0, w[39:36]}, 64'h0);
`else
        check("t1.hand", w, 64'hFF0F00F0F0);
`endif

        // 2: odd-parity instance, 0xA5 and 0x01.
        sel = 2'd2;
        offer("t2a", 9'h0A5);
        capture("t2a", 9'h0A5, 8, 1, 1'b1, 1'b0, 9'h000, 0, w);
        offer("t2b", 9'h001);
        capture("t2b", 9'h001, 8, 1, 1'b1, 1'b0, 9'h000, 0, iw);
`ifdef UART_TX_PARITY_EN
        check("t2.odd_a5", {60'd0, w[39:36]}, 64'hF);
        check("t2.odd_01", {60'd0, iw[39:36]}, 64'h0);
`endif

        // 3: 5 data bits, 2 stop bits, 0x13.
        sel = 2'd1;
        offer("t3", 9'h013);
        capture("t3", 9'h013, 5, 2, 1'b0, 1'b0, 9'h000, 0, w);
`ifdef UART_TX_PARITY_EN
        check("t3.hand", w, 64'hFFFF00FF0);
`else
        check("t3.hand", w, 64'hFFF00FF0);
`endif

        // 4: back-to-back, valid held, 0xAA presented in the Done cycle.
        sel = 2'd0;
        offer("t4a", 9'h055);
        capture("t4a", 9'h055, 8, 1, 1'b0, 1'b1, 9'h0AA, 0, w);
        capture("t4b", 9'h0AA, 8, 1, 1'b0, 1'b0, 9'h000, 0, w);

        // 5: busy drop, 0xFF poked at clock 10 of a 0x00 frame.
        offer("t5", 9'h000);
        capture("t5", 9'h000, 8, 1, 1'b0, 1'b0, 9'h0FF, 10, w);
        iw = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            iw[k] = obs_serial & ~obs_active & obs_ready;
        end
        check("t5.idle_after", iw, 64'hFF);

        // 6: reset during data bit 3 of a 0x00 frame, then a clean 0x3C frame.
        offer("t6", 9'h000);
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
        end
        check("t6.pre_rst_line", {62'd0, obs_serial, obs_active}, 64'b01);
        rst = 1'b1;
        #1;
        check("t6.async", {61'd0, obs_serial, obs_active, obs_done}, 64'b100);
        dseen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (obs_done) dseen = 1'b1;
        end
        rst = 1'b0;
        iw = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (obs_done) dseen = 1'b1;
            iw[k] = obs_serial & obs_ready;
        end
        check("t6.no_done", {63'd0, dseen}, 64'd0);
        check("t6.idle", iw, 64'hFFFFF);
        offer("t6b", 9'h03C);
        capture("t6b", 9'h03C, 8, 1, 1'b0, 1'b0, 9'h000, 0, w);
`ifdef UART_TX_PARITY_EN
        check("t6b.hand", w, 64'hF000FFFF000);
`else
        check("t6b.hand", w, 64'hF00FFFF000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
